ysyx_23060184_trap_seq: RTL and testbench

//   Trap/return sequencer: the initiator side of the CSR register file's trap interface.

---
 rtl/ysyx_23060184_trap_seq.sv | 137 +++++++++++++
 tb/tb_ysyx_23060184_trap_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060184_trap_seq.sv
// Trap/return sequencer: drives CSR side effects for ecall/mret,
// then issues a one-cycle PC redirect to the IFU.
module ysyx_23060184_trap_seq #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_mret,
  input  logic [DATA_WIDTH-1:0]     req_cause,
  input  logic [DATA_WIDTH-1:0]     req_pc,
  output logic                      csr_wen,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0]     csr_wdata,
  output logic [CSR_ADDR_WIDTH-1:0] csr_raddr,
  input  logic [DATA_WIDTH-1:0]     csr_rdata,
  output logic                      redirect_valid,
  output logic [DATA_WIDTH-1:0]     redirect_pc,
  output logic                      busy
);

  localparam logic [CSR_ADDR_WIDTH-1:0] MSTATUS =
    CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] MTVEC =
    CSR_ADDR_WIDTH'(12'h305);
  localparam logic [CSR_ADDR_WIDTH-1:0] MEPC =
    CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] MCAUSE =
    CSR_ADDR_WIDTH'(12'h342);

  typedef enum logic [2:0] {
    IDLE, EPC, CAUSE, STAT, VEC, MSTAT, EPCR, RDIR
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] cause_q;

  function automatic logic [DATA_WIDTH-1:0] trap_status(
    input logic [DATA_WIDTH-1:0] s
  );
    logic [DATA_WIDTH-1:0] r;
    r         = s;
    r[7]      = s[3];
    r[3]      = 1'b0;
    r[12:11]  = 2'b11;
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mret_status(
    input logic [DATA_WIDTH-1:0] s
  );
    logic [DATA_WIDTH-1:0] r;
    r         = s;
    r[3]      = s[7];
    r[7]      = 1'b1;
    r[12:11]  = 2'b11;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      pc_q        <= '0;
      cause_q     <= '0;
      redirect_pc <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            pc_q    <= req_pc;
            cause_q <= req_cause;
            state   <= req_mret ? MSTAT : EPC;
          end
        end
        EPC:   state <= CAUSE;
        CAUSE: state <= STAT;
        STAT:  state <= VEC;
        VEC: begin
          // direct mode only: mode bits are dropped
          redirect_pc <= {csr_rdata[DATA_WIDTH-1:2], 2'b00};
          state       <= RDIR;
        end
        MSTAT: state <= EPCR;
        EPCR: begin
          redirect_pc <= csr_rdata;
          state       <= RDIR;
        end
        RDIR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // CSR bus decodes straight from state; wdata needs same-cycle rdata
  always_comb begin
    csr_wen   = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    csr_raddr = '0;
    unique case (state)
      EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = MEPC;
        csr_wdata = pc_q;
      end
      CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = MCAUSE;
        csr_wdata = cause_q;
      end
      STAT: begin
        csr_raddr = MSTATUS;
        csr_wen   = 1'b1;
        csr_waddr = MSTATUS;
        csr_wdata = trap_status(csr_rdata);
      end
      VEC:  csr_raddr = MTVEC;
      MSTAT: begin
        csr_raddr = MSTATUS;
        csr_wen   = 1'b1;
        csr_waddr = MSTATUS;
        csr_wdata = mret_status(csr_rdata);
      end
      EPCR: csr_raddr = MEPC;
      default: begin
      end
    endcase
  end

  assign req_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign redirect_valid = (state == RDIR);

endmodule

// File: tb/tb_ysyx_23060184_trap_seq.sv
// Bench for the trap sequencer: a CSR file model plus a
// per-cycle scoreboard of expected bus/redirect values.
module tb_ysyx_23060184_trap_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_mret;
  logic [31:0] req_cause;
  logic [31:0] req_pc;
  logic        csr_wen;
  logic [9:0]  csr_waddr;
  logic [31:0] csr_wdata;
  logic [9:0]  csr_raddr;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  ysyx_23060184_trap_seq dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mret(req_mret), .req_cause(req_cause),
    .req_pc(req_pc),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wen;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic        rv;
    logic        ready;
    logic        busy;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  exp_t obs;
  exp_t ex;
  assign obs = {csr_wen, csr_waddr, csr_wdata, csr_raddr,
                redirect_valid, req_ready, busy, redirect_pc};

  int n_chk = 0;
  int n_fail = 0;

  // CSR file model: combinational read, write on the clock edge
  logic [31:0] m_status, m_tvec, m_epc, m_cause;
  logic [31:0] e_status, e_tvec, e_epc, e_cause, e_rpc;

  always_comb begin
    case (csr_raddr)
      10'h300: csr_rdata = m_status;
      10'h305: csr_rdata = m_tvec;
      10'h341: csr_rdata = m_epc;
      10'h342: csr_rdata = m_cause;
      default: csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (csr_wen) begin
      case (csr_waddr)
        10'h300: m_status <= csr_wdata;
        10'h305: m_tvec   <= csr_wdata;
        10'h341: m_epc    <= csr_wdata;
        10'h342: m_cause  <= csr_wdata;
        default: ;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, want finish");
    $fatal(1, "watchdog");
  end

  task automatic set_csrs(input logic [31:0] st, tv, ep, ca);
    m_status = st; m_tvec = tv; m_epc = ep; m_cause = ca;
    e_status = st; e_tvec = tv; e_epc = ep; e_cause = ca;
  endtask

  function automatic exp_t mk(input logic w, input logic [9:0] wa,
                              input logic [31:0] wd,
                              input logic [9:0] ra,
                              input logic rv, input logic idle);
    exp_t r;
    r.wen = w; r.waddr = wa; r.wdata = wd; r.raddr = ra;
    r.rv = rv; r.ready = idle; r.busy = !idle; r.rpc = e_rpc;
    return r;
  endfunction

  task automatic push_idle();
    sb.push_back(mk(1'b0, 10'h0, 32'h0, 10'h0, 1'b0, 1'b1));
  endtask

  task automatic push_trap(input logic [31:0] pc, cause);
    logic [31:0] ns;
    ns = (e_status & ~32'h1888) | 32'h1800
       | (((e_status >> 3) & 32'h1) << 7);
    sb.push_back(mk(1'b1, 10'h341, pc, 10'h0, 1'b0, 1'b0));
    sb.push_back(mk(1'b1, 10'h342, cause, 10'h0, 1'b0, 1'b0));
    sb.push_back(mk(1'b1, 10'h300, ns, 10'h300, 1'b0, 1'b0));
    sb.push_back(mk(1'b0, 10'h0, 32'h0, 10'h305, 1'b0, 1'b0));
    e_rpc = e_tvec & 32'hFFFF_FFFC;
    sb.push_back(mk(1'b0, 10'h0, 32'h0, 10'h0, 1'b1, 1'b0));
    e_status = ns; e_epc = pc; e_cause = cause;
  endtask

  task automatic push_mret();
    logic [31:0] ns;
    ns = (e_status & ~32'h1888) | 32'h1880
       | (((e_status >> 7) & 32'h1) << 3);
    sb.push_back(mk(1'b1, 10'h300, ns, 10'h300, 1'b0, 1'b0));
    sb.push_back(mk(1'b0, 10'h0, 32'h0, 10'h341, 1'b0, 1'b0));
    e_rpc = e_epc;
    sb.push_back(mk(1'b0, 10'h0, 32'h0, 10'h0, 1'b1, 1'b0));
    e_status = ns;
  endtask

  task automatic test_reset();
    logic [31:0] saved;
    rstn = 1'b0; req_valid = 1'b0; req_mret = 1'b0;
    req_pc = 32'h0; req_cause = 32'h0; e_rpc = 32'h0;
    set_csrs(32'h8, 32'h8000_0101, 32'h0, 32'h0);
    #12;
    push_idle(); ex = sb.pop_front(); n_chk++;
    if (obs !== ex) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, ex);
    end
    @(negedge clk); rstn = 1'b1;
    saved = e_status;
    req_valid = 1'b1; req_pc = 32'h8000_0040; req_cause = 32'd11;
    push_trap(req_pc, req_cause);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 1'b0;
      ex = sb.pop_front(); n_chk++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL reset_pre[%0d]: got %h want %h", i, obs, ex);
      end
    end
    #2 rstn = 1'b0;
    #1;
    sb.delete(); e_rpc = 32'h0; e_status = saved;
    push_idle(); ex = sb.pop_front(); n_chk++;
    if (obs !== ex) begin
      n_fail++;
      $display("FAIL reset_abort: got %h want %h", obs, ex);
    end
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_idle();
      @(negedge clk);
      ex = sb.pop_front(); n_chk++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL reset_post[%0d]: got %h want %h", i, obs, ex);
      end
    end
    n_chk++;
    if ({m_status, m_epc, m_cause} !== {e_status, e_epc, e_cause}) begin
      n_fail++;
      $display("FAIL reset_csrs: got %h %h %h want %h %h %h",
               m_status, m_epc, m_cause, e_status, e_epc, e_cause);
    end
  endtask

  task automatic test_ecall();
    set_csrs(32'h8, 32'h8000_0101, 32'h0, 32'h0);
    req_valid = 1'b1; req_mret = 1'b0;
    req_pc = 32'h8000_0010; req_cause = 32'd11;
    push_trap(req_pc, req_cause); push_idle();
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 1'b0;
      ex = sb.pop_front(); n_chk++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL ecall[%0d]: got %h want %h", i, obs, ex);
      end
    end
    n_chk++;
    if ({m_status, m_epc, m_cause} !== {e_status, e_epc, e_cause}) begin
      n_fail++;
      $display("FAIL ecall_csrs: got %h %h %h want %h %h %h",
               m_status, m_epc, m_cause, e_status, e_epc, e_cause);
    end
  endtask

  task automatic test_mret();
    set_csrs(32'h1880, 32'h8000_0101, 32'h8000_0014, 32'd11);
    req_valid = 1'b1; req_mret = 1'b1;
    req_pc = 32'h1234_5678; req_cause = 32'h0;
    push_mret(); push_idle();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 1'b0;
      ex = sb.pop_front(); n_chk++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL mret[%0d]: got %h want %h", i, obs, ex);
      end
    end
    n_chk++;
    if (m_status !== e_status) begin
      n_fail++;
      $display("FAIL mret_status: got %h want %h", m_status, e_status);
    end
    req_mret = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_csrs(32'h8, 32'h8000_0200, 32'h0, 32'h0);
    req_valid = 1'b1; req_mret = 1'b0;
    req_pc = 32'h8000_0080; req_cause = 32'd11;
    push_trap(req_pc, req_cause); push_idle();
    push_mret(); push_idle();
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ex = sb.pop_front(); n_chk++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %h want %h", i, obs, ex);
      end
      if (i == 5) req_mret = 1'b1;
      if (i == 6) begin
        req_valid = 1'b0; req_mret = 1'b0;
      end
    end
    n_chk++;
    if ({m_status, m_epc} !== {e_status, e_epc}) begin
      n_fail++;
      $display("FAIL b2b_csrs: got %h %h want %h %h",
               m_status, m_epc, e_status, e_epc);
    end
  endtask

  task automatic test_busy();
    set_csrs(32'h0, 32'h8000_0304, 32'h0, 32'h0);
    req_valid = 1'b1; req_mret = 1'b0;
    req_pc = 32'h8000_1000; req_cause = 32'h8000_0007;
    push_trap(req_pc, req_cause); push_idle(); push_idle();
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ex = sb.pop_front(); n_chk++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL busy[%0d]: got %h want %h", i, obs, ex);
      end
      req_valid = (i < 4) ? i[0] == 1'b0 : 1'b0;
      req_mret  = 1'b1;
      req_pc    = $urandom; req_cause = $urandom;
    end
    req_mret = 1'b0;
    n_chk++;
    if ({m_status, m_epc, m_cause} !== {e_status, e_epc, e_cause}) begin
      n_fail++;
      $display("FAIL busy_csrs: got %h %h %h want %h %h %h",
               m_status, m_epc, m_cause, e_status, e_epc, e_cause);
    end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_mret();
    test_back_to_back();
    test_busy();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
